// File: rtl/fconv_pkg.sv
// Shared types and constants for the float/int conversion arbiter.
package fconv_pkg;

    typedef enum logic {
        FCONV_FTOI = 1'b0,
        FCONV_ITOF = 1'b1
    } fconv_op_e;

    localparam logic [31:0] INT_MAX      = 32'h7FFF_FFFF;
    localparam logic [31:0] INT_MIN      = 32'h8000_0000;
    // -2^31 is the only float with exponent >= 158 that converts exactly.
    localparam logic [31:0] FTOI_EXACT_MIN = 32'hCF00_0000;
    localparam int          FCONV_TAG_W  = 5;

endpackage

// File: rtl/fconv_core.sv
// Combinational ftoi (truncate) / itof (round-nearest-even) datapath.
// Optional exception flag generated only when FCONV_EXC_EN is defined.
module fconv_core
    import fconv_pkg::*;
(
    input  fconv_op_e   op,
    input  logic [31:0] data,
    output logic [31:0] result
`ifdef FCONV_EXC_EN
    ,
    output logic        exc
`endif
);

    logic [7:0]  expo;
    logic [31:0] mant;
    logic [31:0] mag_f;
    logic [31:0] ftoi_res;
    logic [31:0] mag_i;
    logic [31:0] norm;
    logic [4:0]  lead;
    logic        rnd_up;
    logic [24:0] rnd;
    logic [7:0]  exp_i;
    logic [31:0] itof_res;

    always_comb begin
        expo = data[30:23];
        mant = {8'd0, 1'b1, data[22:0]};
        if (expo >= 8'd150) begin
            mag_f = mant << (expo - 8'd150);
        end else begin
            mag_f = mant >> (8'd150 - expo);
        end
        if (expo <= 8'd126) begin
            ftoi_res = '0;
        end else if (expo >= 8'd158) begin
            ftoi_res = data[31] ? INT_MIN : INT_MAX;
        end else begin
            ftoi_res = data[31] ? (~mag_f + 32'd1) : mag_f;
        end
    end

    // Normalise so the leading one sits at bit 31; bits [7:0] then hold guard/sticky.
    always_comb begin
        mag_i = data[31] ? (~data + 32'd1) : data;
        lead  = '0;
        for (int i = 0; i < 32; i++) begin
            if (mag_i[i]) begin
                lead = 5'(i);
            end
        end
        norm     = mag_i << (5'd31 - lead);
        rnd_up   = norm[7] && ((|norm[6:0]) || norm[8]);
        rnd      = {1'b0, norm[31:8]} + {24'd0, rnd_up};
        exp_i    = 8'd127 + {3'd0, lead} + {7'd0, rnd[24]};
        itof_res = (mag_i == 32'd0) ? 32'd0
                 : {data[31], exp_i, (rnd[24] ? rnd[23:1] : rnd[22:0])};
    end

    assign result = (op == FCONV_ITOF) ? itof_res : ftoi_res;

`ifdef FCONV_EXC_EN
    assign exc = (op == FCONV_FTOI) && (expo >= 8'd158) && (data != FTOI_EXACT_MIN);
`endif

endmodule

// File: rtl/fconv_arb.sv
// Two-requester round-robin arbiter feeding a 2-stage conversion pipeline.
// Optional res_exc output enabled by defining FCONV_EXC_EN.
module fconv_arb
    import fconv_pkg::*;
#(
    parameter int TAG_W = FCONV_TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic             req0_op,
    input  logic [31:0]      req0_data,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic             req1_op,
    input  logic [31:0]      req1_data,
    input  logic [TAG_W-1:0] req1_tag,
    input  logic             flush,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic             res_src,
    output logic [TAG_W-1:0] res_tag
`ifdef FCONV_EXC_EN
    ,
    output logic             res_exc
`endif
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // res_* hold steady while res_valid=1 and res_ready=0.
    logic             ptr_q, ptr_d;
    logic             s1_valid_q, s1_valid_d;
    fconv_op_e        s1_op_q, s1_op_d;
    logic [31:0]      s1_data_q, s1_data_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    logic             s1_src_q, s1_src_d;
    logic             s2_valid_q, s2_valid_d;
    logic [31:0]      s2_data_q, s2_data_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
    logic             s2_src_q, s2_src_d;
    logic             s2_stall, can_accept, gnt, accept;
    logic [31:0]      core_result;
`ifdef FCONV_EXC_EN
    logic             s2_exc_q, s2_exc_d;
    logic             core_exc;
`endif

    fconv_core u_core (
        .op     (s1_op_q),
        .data   (s1_data_q),
        .result (core_result)
`ifdef FCONV_EXC_EN
        ,
        .exc    (core_exc)
`endif
    );

    always_comb begin
        s2_stall   = s2_valid_q && !res_ready;
        can_accept = !rst && !flush && (!s1_valid_q || !s2_stall);
        // Pointer's requester if it is valid, otherwise the other one.
        gnt        = ptr_q ? req1_valid : !req0_valid;
        req0_ready = can_accept && req0_valid && !gnt;
        req1_ready = can_accept && req1_valid && gnt;
        accept     = req0_ready || req1_ready;
        ptr_d      = accept ? !gnt : ptr_q;

        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_data_d  = s1_data_q;
        s1_tag_d   = s1_tag_q;
        s1_src_d   = s1_src_q;
        if (flush) begin
            s1_valid_d = 1'b0;
        end else if (accept) begin
            s1_valid_d = 1'b1;
            s1_op_d    = gnt ? fconv_op_e'(req1_op) : fconv_op_e'(req0_op);
            s1_data_d  = gnt ? req1_data : req0_data;
            s1_tag_d   = gnt ? req1_tag : req0_tag;
            s1_src_d   = gnt;
        end else if (!s2_stall) begin
            s1_valid_d = 1'b0;
        end

        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_tag_d   = s2_tag_q;
        s2_src_d   = s2_src_q;
`ifdef FCONV_EXC_EN
        s2_exc_d   = s2_exc_q;
`endif
        if (flush) begin
            s2_valid_d = 1'b0;
        end else if (!s2_stall) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = core_result;
                s2_tag_d  = s1_tag_q;
                s2_src_d  = s1_src_q;
`ifdef FCONV_EXC_EN
                s2_exc_d  = core_exc;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_op_q    <= FCONV_FTOI;
            s1_data_q  <= '0;
            s1_tag_q   <= '0;
            s1_src_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_tag_q   <= '0;
            s2_src_q   <= 1'b0;
`ifdef FCONV_EXC_EN
            s2_exc_q   <= 1'b0;
`endif
        end else begin
            ptr_q      <= ptr_d;
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_data_q  <= s1_data_d;
            s1_tag_q   <= s1_tag_d;
            s1_src_q   <= s1_src_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_tag_q   <= s2_tag_d;
            s2_src_q   <= s2_src_d;
`ifdef FCONV_EXC_EN
            s2_exc_q   <= s2_exc_d;
`endif
        end
    end

    assign res_valid = s2_valid_q;
    assign res_data  = s2_data_q;
    assign res_tag   = s2_tag_q;
    assign res_src   = s2_src_q;
`ifdef FCONV_EXC_EN
    assign res_exc   = s2_exc_q;
`endif

endmodule

// File: tb/tb_fconv_arb.sv
// Bench for fconv_arb: directed vectors plus randomized traffic against a queue-level reference model.
module tb_fconv_arb;
    import fconv_pkg::*;

    localparam int TW = 5;

    logic          clk = 1'b0;
    logic          rst, flush, res_ready;
    logic          req0_valid, req0_ready, req0_op;
    logic [31:0]   req0_data;
    logic [TW-1:0] req0_tag;
    logic          req1_valid, req1_ready, req1_op;
    logic [31:0]   req1_data;
    logic [TW-1:0] req1_tag;
    logic          res_valid, res_src;
    logic [31:0]   res_data;
    logic [TW-1:0] res_tag;
`ifdef FCONV_EXC_EN
    logic          res_exc;
`endif

    always #5 clk = ~clk;

    fconv_arb #(.TAG_W(TW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_data(req0_data), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_data(req1_data), .req1_tag(req1_tag),
        .flush(flush),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_src(res_src), .res_tag(res_tag)
`ifdef FCONV_EXC_EN
        , .res_exc(res_exc)
`endif
    );

    int checks = 0;
    int errors = 0;

    // In-flight entry: [39]=in output stage, [38]=exc, [37]=src, [36:32]=tag, [31:0]=result
    logic [39:0] exp_q[$];
    logic        ptr_m;

    logic        smp_valid, smp_r0, smp_r1, smp_exc;
    logic [31:0] smp_data;
    logic [TW-1:0] smp_tag;
    logic        smp_src;

    logic [31:0] d_in  [8] = '{32'h40490FDB, 32'hC0000000, 32'h3F000000, 32'h4F000000,
                               32'hCF000000, 32'h00000003, 32'hFFFFFFFF, 32'h01000001};
    logic        d_op  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] d_exp [8] = '{32'h00000003, 32'hFFFFFFFE, 32'h00000000, 32'h7FFFFFFF,
                               32'h80000000, 32'h40400000, 32'hBF800000, 32'h4B800000};
    logic        d_exc [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic longint p2(input int n);
        longint r = 1;
        repeat (n) r = r * 2;
        return r;
    endfunction

    // Truncating float-to-int from value = 1.m * 2^(e-127).
    function automatic logic [31:0] ref_ftoi(input logic [31:0] x);
        int     e = int'(x[30:23]);
        longint m = longint'({1'b1, x[22:0]});
        longint v;
        if (e <= 126) return 32'd0;
        if (e >= 158) return x[31] ? 32'h80000000 : 32'h7FFFFFFF;
        if (e >= 150) v = m * p2(e - 150);
        else          v = m / p2(150 - e);
        if (x[31]) v = -v;
        return v[31:0];
    endfunction

    function automatic logic ref_exc(input logic [31:0] x);
        return (int'(x[30:23]) >= 158) && (x != 32'hCF000000);
    endfunction

    // Int-to-float: find floor(log2), divide down to 24 significant bits, round half to even.
    function automatic logic [31:0] ref_itof(input logic [31:0] x);
        longint v = longint'($signed(x));
        longint mag = (v < 0) ? -v : v;
        longint q, r, d, frac;
        int     e = 0;
        logic [31:0] res;
        if (mag == 0) return 32'd0;
        while (mag >= p2(e + 1)) e++;
        if (e <= 23) begin
            frac = mag * p2(23 - e) - p2(23);
        end else begin
            d = p2(e - 23);
            q = mag / d;
            r = mag % d;
            if (r > d / 2 || (r == d / 2 && (q % 2) == 1)) q++;
            if (q == p2(24)) begin
                q = p2(23);
                e++;
            end
            frac = q - p2(23);
        end
        res[31]    = (v < 0);
        res[30:23] = 8'(e + 127);
        res[22:0]  = 23'(frac);
        return res;
    endfunction

    // One clock: sample and compare at negedge, update the model, return #1 after posedge.
    task automatic tick();
        logic        ov, s1b, stall, can, g, e0, e1;
        logic [39:0] hd, ent;
        logic [31:0] din;
        @(negedge clk);
        smp_valid = res_valid; smp_data = res_data; smp_tag = res_tag; smp_src = res_src;
        smp_r0 = req0_ready; smp_r1 = req1_ready;
`ifdef FCONV_EXC_EN
        smp_exc = res_exc;
`else
        smp_exc = 1'b0;
`endif
        if (rst) begin
            chk("rst_ready0", 32'(req0_ready), 32'd0);
            chk("rst_ready1", 32'(req1_ready), 32'd0);
            exp_q.delete();
            ptr_m = 1'b0;
        end else begin
            ov    = (exp_q.size() > 0) && exp_q[0][39];
            s1b   = (exp_q.size() > 0) && !exp_q[exp_q.size()-1][39];
            stall = ov && !res_ready;
            can   = !flush && (!s1b || !stall);
            g = ptr_m;
            if (!(g ? req1_valid : req0_valid)) g = !g;
            e0 = can && req0_valid && !g;
            e1 = can && req1_valid && g;
            chk("ready0", 32'(req0_ready), 32'(e0));
            chk("ready1", 32'(req1_ready), 32'(e1));
            chk("res_valid", 32'(res_valid), 32'(ov));
            if (ov) begin
                hd = exp_q[0];
                chk("res_data", res_data, hd[31:0]);
                chk("res_tag", 32'(res_tag), 32'(hd[36:32]));
                chk("res_src", 32'(res_src), 32'(hd[37]));
`ifdef FCONV_EXC_EN
                chk("res_exc", 32'(res_exc), 32'(hd[38]));
`endif
            end
            if (flush) begin
                exp_q.delete();
            end else begin
                if (ov && res_ready) void'(exp_q.pop_front());
                if (!stall) foreach (exp_q[i]) exp_q[i][39] = 1'b1;
                if (e0 || e1) begin
                    din = g ? req1_data : req0_data;
                    if (g ? req1_op : req0_op)
                        ent = {1'b0, 1'b0, g, (g ? req1_tag : req0_tag), ref_itof(din)};
                    else
                        ent = {1'b0, ref_exc(din), g, (g ? req1_tag : req0_tag), ref_ftoi(din)};
                    exp_q.push_back(ent);
                    ptr_m = !g;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req0_valid = 1'b0; req1_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] gen_data(input logic op);
        int k = $urandom_range(0, 9);
        if (!op) begin
            case (k)
                0: return 32'h7F800000;
                1: return 32'hFFC00000;
                2: return 32'hCF000000;
                default: return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 165)),
                                 23'($urandom)};
            endcase
        end else begin
            case (k)
                0, 1: return 32'($signed(32'($urandom_range(0, 40))) - 20);
                2:    return 32'h80000000;
                3:    return (32'd1 << $urandom_range(24, 30)) + 32'($urandom_range(0, 300));
                default: return $urandom;
            endcase
        end
    endfunction

    task automatic rand_req(input int n);
        if (n == 0) begin
            req0_op = 1'($urandom_range(0, 1)); req0_data = gen_data(req0_op);
            req0_tag = TW'($urandom);
        end else begin
            req1_op = 1'($urandom_range(0, 1)); req1_data = gen_data(req1_op);
            req1_tag = TW'($urandom);
        end
    endtask

    initial begin
        int          n_acc;
        logic [31:0] held;
        rst = 1'b1; res_ready = 1'b1;
        idle();
        req0_op = 1'b0; req0_data = '0; req0_tag = '0;
        req1_op = 1'b0; req1_data = '0; req1_tag = '0;
        ptr_m = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("reset_valid", 32'(res_valid), 32'd0);
        chk("reset_data", res_data, 32'd0);
        chk("reset_src", 32'(res_src), 32'd0);
        chk("reset_tag", 32'(res_tag), 32'd0);
`ifdef FCONV_EXC_EN
        chk("reset_exc", 32'(res_exc), 32'd0);
`endif

        // Known conversion vectors, one at a time through requester 0
        for (int i = 0; i < 8; i++) begin
            req0_valid = 1'b1; req0_op = d_op[i]; req0_data = d_in[i];
            req0_tag = (i == 0) ? TW'(7) : TW'(i);
            tick();
            chk("vec_accept", 32'(smp_r0), 32'd1);
            idle();
            tick();
            chk("vec_early", 32'(smp_valid), 32'd0);
            tick();
            chk("vec_valid", 32'(smp_valid), 32'd1);
            chk("vec_data", smp_data, d_exp[i]);
            chk("vec_tag", 32'(smp_tag), (i == 0) ? 32'd7 : 32'(i));
            chk("vec_src", 32'(smp_src), 32'd0);
`ifdef FCONV_EXC_EN
            chk("vec_exc", 32'(smp_exc), 32'(d_exc[i]));
`endif
        end

        // Both requesters saturated, consumer always ready
        do_reset();
        for (int i = 0; i < 12; i++) begin
            req0_valid = 1'b1; req1_valid = 1'b1; rand_req(0); rand_req(1);
            tick();
            chk("rr_gnt", {30'd0, smp_r1, smp_r0}, (i % 2 == 1) ? 32'd2 : 32'd1);
            if (i >= 2) chk("rr_stream", 32'(smp_valid), 32'd1);
        end

        // Backpressure for 5 cycles
        do_reset();
        res_ready = 1'b0;
        n_acc = 0;
        held = '0;
        for (int i = 0; i < 5; i++) begin
            req0_valid = 1'b1; req1_valid = 1'b1; rand_req(0); rand_req(1);
            tick();
            n_acc += int'(smp_r0) + int'(smp_r1);
            if (i == 2) held = smp_data;
            if (i > 2) chk("bp_stable", smp_data, held);
        end
        chk("bp_accepts", 32'(n_acc), 32'd2);
        idle();
        res_ready = 1'b1;
        repeat (4) tick();

        // Flush with two ops in flight; pointer must survive the flush
        do_reset();
        res_ready = 1'b0;
        req1_valid = 1'b1; rand_req(1);
        tick();
        req0_valid = 1'b1; rand_req(0);
        tick();
        flush = 1'b1;
        tick();
        chk("flush_ready", {30'd0, smp_r1, smp_r0}, 32'd0);
        flush = 1'b0;
        res_ready = 1'b1;
        tick();
        chk("flush_cleared", 32'(smp_valid), 32'd0);
        chk("flush_ptr", {30'd0, smp_r1, smp_r0}, 32'd2);
        idle();
        repeat (4) tick();

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 1500; i++) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            rand_req(0); rand_req(1);
            res_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 29) == 0);
            rst       = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        idle();
        res_ready = 1'b1;
        repeat (4) tick();
        chk("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fconv_arb.md
FCONV_ARB -- requirements
Module: fconv_arb

Interface
REQ-001 SHALL have parameter TAG_W, default 5: width of the destination-register tag carried with each op.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port reqN_valid  input  1  requester N (N = 0, 1) presents an op.
REQ-005 SHALL have port reqN_ready  output  1  op from requester N is accepted this cycle.
REQ-006 SHALL have port reqN_op  input  1  op select: 0 = ftoi, 1 = itof.
REQ-007 SHALL have port reqN_data  input  32  operand: IEEE single for ftoi, two's-complement int for itof.
REQ-008 SHALL have port reqN_tag  input  TAG_W  tag, returned unchanged with the result.
REQ-009 SHALL have port flush  input  1  discard all in-flight ops.
REQ-010 SHALL have port res_valid  output  1  result present.
REQ-011 SHALL have port res_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port res_data  output  32  converted value.
REQ-013 SHALL have port res_src  output  1  requester index of the result.
REQ-014 SHALL have port res_tag  output  TAG_W  tag of the result.
REQ-015 SHALL have port res_exc  output  1  invalid/overflow flag; present only under FCONV_EXC_EN.

Function
REQ-016 SHALL arbitrate round-robin: grant the requester the pointer selects when it is valid, otherwise the other one; after each accept the pointer moves to the non-granted requester.
REQ-017 SHALL accept at most one op per cycle; reqN_ready SHALL be 1 only for the granted requester, only when stage S1 is free or advancing, and never while flush=1.
REQ-018 SHALL use two valid-qualified stages: S1 registers op/data/tag/src; S2 registers the converted result and drives res_*.
REQ-019 SHALL deliver a result on res_* 2 cycles after accept when there is no backpressure, and sustain 1 result per cycle while res_ready=1.
REQ-020 SHALL stall S2 while res_valid=1 and res_ready=0, holding all res_* stable; S1 SHALL stall when S2 stalls; results SHALL leave in accept order.
REQ-021 ftoi SHALL truncate toward zero: 0 when exponent <= 126; 0x7FFFFFFF (s=0) or 0x80000000 (s=1) when exponent >= 158, NaN/Inf included.
REQ-022 itof SHALL round to nearest, ties to even; 0 SHALL map to 0x00000000.
REQ-023 flush=1 SHALL clear S1 and S2 valid at the next edge; the arbitration pointer SHALL be unchanged and no accept SHALL occur in that cycle.

Reset
REQ-024 On rst=1 at an edge: S1/S2 valid cleared, pointer = requester 0, res_valid=0, res_data=0, res_src=0, res_tag=0, res_exc=0; rst SHALL take priority over flush and handshakes, and in-flight ops SHALL be dropped.
REQ-025 reqN_ready SHALL be 0 during any cycle in which rst=1.

Configuration
REQ-026 With FCONV_EXC_EN defined: res_exc port present; res_exc=1 for ftoi with exponent >= 158, except input 0xCF000000 (exactly -2^31), and 0 for every itof.
REQ-027 Without FCONV_EXC_EN: no res_exc port and no exception logic; all other behaviour identical.

Structure
REQ-028 Package fconv_pkg SHALL hold the op typedef (FCONV_FTOI, FCONV_ITOF), the constants INT_MAX=0x7FFFFFFF and INT_MIN=0x80000000, and the default tag width.
REQ-029 The combinational ftoi/itof datapath SHALL be a sub-module fconv_core placed between S1 and S2; arbitration, pipeline and flush control SHALL stay in fconv_arb.

Verification
REQ-030 req0 ftoi 0x40490FDB, tag 7 -> 2 cycles later res_data=0x00000003, res_src=0, res_tag=7.
REQ-031 ftoi 0xC0000000 -> 0xFFFFFFFE; 0x3F000000 -> 0; 0x4F000000 -> 0x7FFFFFFF with res_exc=1; 0xCF000000 -> 0x80000000 with res_exc=0 (res_exc checks under FCONV_EXC_EN only).
REQ-032 itof 0x00000003 -> 0x40400000; 0xFFFFFFFF -> 0xBF800000; 0x01000001 -> 0x4B800000.
REQ-033 Both requesters continuously valid, res_ready=1, starting after reset -> grants 0,1,0,1,...; one result per cycle.
REQ-034 Continuous requests with res_ready=0 for 5 cycles -> exactly 2 accepted, res_* stable throughout; after release the results appear in accept order.
REQ-035 flush with 2 ops in flight -> res_valid=0 next cycle, neither result ever emitted, next grant follows the unchanged pointer.
